// File: rtl/truth_table_sweep.sv
// truth_table_sweep: steps a combinational block through every input vector and
// counts mismatches against a golden table.
module truth_table_sweep #(
  parameter int N_IN = 3,
  parameter int SETTLE = 1,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'hE8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            err_valid,
  output logic [N_IN-1:0] first_err_idx
);
  localparam int WW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IN_LAST = '1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [N_IN-1:0] dut_in_n, first_err_idx_n;
  logic [N_IN:0] err_count_n, err_inc;
  logic busy_n, done_n, pass_n, err_valid_n, mismatch;
  always_comb begin
    state_n = state;
    wcnt_n = wcnt;
    dut_in_n = dut_in;
    busy_n = busy;
    done_n = done;
    pass_n = pass;
    err_count_n = err_count;
    err_valid_n = err_valid;
    first_err_idx_n = first_err_idx;
    mismatch = dut_out != EXPECTED[dut_in];
    err_inc = err_count + (N_IN+1)'(mismatch);
    if (state != RUN) begin
      if (start) begin
        state_n = RUN;
        wcnt_n = '0;
        dut_in_n = '0;
        busy_n = 1'b1;
        done_n = 1'b0;
        pass_n = 1'b0;
        err_count_n = '0;
        err_valid_n = 1'b0;
        first_err_idx_n = '0;
      end
    end else if (wcnt != W_LAST) begin
      wcnt_n = wcnt + 1'b1;
    end else begin
      err_count_n = err_inc;
      err_valid_n = err_valid | mismatch;
      first_err_idx_n = (mismatch && !err_valid) ? dut_in : first_err_idx;
      if (dut_in == IN_LAST) begin
        // the last vector's sample must count toward pass
        state_n = DONE;
        busy_n = 1'b0;
        done_n = 1'b1;
        pass_n = err_inc == '0;
      end else begin
        dut_in_n = dut_in + 1'b1;
        wcnt_n = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      dut_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      err_valid <= 1'b0;
      first_err_idx <= '0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      dut_in <= dut_in_n;
      busy <= busy_n;
      done <= done_n;
      pass <= pass_n;
      err_count <= err_count_n;
      err_valid <= err_valid_n;
      first_err_idx <= first_err_idx_n;
    end
  end
endmodule

// File: tb/tb_truth_table_sweep.sv
// tb_truth_table_sweep: directed checks of the sweeper with SETTLE=1 and SETTLE=3 instances.
module tb_truth_table_sweep;
  logic clk = 1'b0, reset = 1'b1, start1 = 1'b0, start3 = 1'b0;
  logic [2:0] in1, in3, first1, first3;
  logic [3:0] ec1, ec3;
  logic out1, out3, busy1, busy3, done1, done3, pass1, pass3, ev1, ev3;
  int mode = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // bit2=a, bit1=b, bit0=c; modes: 0 maj, 1 a&b|c, 2 parity, 3 const0, 4 const1, 5 ~maj
  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction
  always_comb begin
    out1 = maj(in1);
    if (mode == 1) out1 = (in1[2] & in1[1]) | in1[0];
    if (mode == 2) out1 = ^in1;
    if (mode == 3) out1 = 1'b0;
    if (mode == 4) out1 = 1'b1;
    if (mode == 5) out1 = ~maj(in1);
  end
  assign out3 = maj(in3);
  truth_table_sweep #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hE8)) u1 (
    .clk(clk), .reset(reset), .start(start1), .dut_in(in1), .dut_out(out1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(ec1), .err_valid(ev1), .first_err_idx(first1));
  truth_table_sweep #(.N_IN(3), .SETTLE(3), .EXPECTED(8'hE8)) u3 (
    .clk(clk), .reset(reset), .start(start3), .dut_in(in3), .dut_out(out3), .busy(busy3),
    .done(done3), .pass(pass3), .err_count(ec3), .err_valid(ev3), .first_err_idx(first3));
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse1;
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    cyc(2);
    checks++; if ({in1, busy1, done1, pass1, ec1, ev1, first1} !== 15'd0) begin errors++; $display("FAIL reset_u1 got %h exp 0", {in1, busy1, done1, pass1, ec1, ev1, first1}); end
    checks++; if ({in3, busy3, done3, pass3, ec3, ev3, first3} !== 15'd0) begin errors++; $display("FAIL reset_u3 got %h exp 0", {in3, busy3, done3, pass3, ec3, ev3, first3}); end
    start1 = 1'b1;
    cyc();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_beats_start busy got %b exp 0", busy1); end
    reset = 1'b0;
    start1 = 1'b0;
    cyc();
    checks++; if ({busy1, done1} !== 2'b00) begin errors++; $display("FAIL idle_after_reset busy/done got %b exp 00", {busy1, done1}); end
  endtask
  task automatic test_majority;
    mode = 0;
    pulse1();
    for (int i = 0; i < 8; i++) begin
      checks++; if ({busy1, in1} !== {1'b1, 3'(i)}) begin errors++; $display("FAIL maj_step%0d busy,dut_in got %h exp %h", i, {busy1, in1}, {1'b1, 3'(i)}); end
      cyc();
    end
    checks++; if ({busy1, done1, pass1, ec1, ev1} !== {3'b011, 4'd0, 1'b0}) begin errors++; $display("FAIL maj_result got %b exp 01100000", {busy1, done1, pass1, ec1, ev1}); end
    cyc();
    checks++; if ({done1, in1} !== {1'b1, 3'd7}) begin errors++; $display("FAIL maj_hold got %h exp f", {done1, in1}); end
  endtask
  task automatic test_mismatch;
    mode = 1;
    pulse1();
    cyc(8);
    checks++; if ({done1, pass1, ev1, ec1, first1} !== {3'b101, 4'd1, 3'd1}) begin errors++; $display("FAIL abc_result got %b exp %b", {done1, pass1, ev1, ec1, first1}, {3'b101, 4'd1, 3'd1}); end
    mode = 2;
    pulse1();
    checks++; if ({done1, ev1, ec1} !== 6'd0) begin errors++; $display("FAIL restart_clears got %b exp 0", {done1, ev1, ec1}); end
    cyc(8);
    checks++; if ({done1, pass1, ev1, ec1, first1} !== {3'b101, 4'd6, 3'd1}) begin errors++; $display("FAIL parity_result got %b exp %b", {done1, pass1, ev1, ec1, first1}, {3'b101, 4'd6, 3'd1}); end
  endtask
  task automatic test_constants;
    mode = 3;
    pulse1();
    cyc(8);
    checks++; if ({done1, pass1, ec1, first1} !== {2'b10, 4'd4, 3'd3}) begin errors++; $display("FAIL const0 got %b exp %b", {done1, pass1, ec1, first1}, {2'b10, 4'd4, 3'd3}); end
    mode = 4;
    pulse1();
    cyc(8);
    checks++; if ({done1, pass1, ec1, first1} !== {2'b10, 4'd4, 3'd0}) begin errors++; $display("FAIL const1 got %b exp %b", {done1, pass1, ec1, first1}, {2'b10, 4'd4, 3'd0}); end
    mode = 5;
    pulse1();
    cyc(8);
    checks++; if ({done1, pass1, ev1, ec1, first1} !== {3'b101, 4'd8, 3'd0}) begin errors++; $display("FAIL invmaj got %b exp %b", {done1, pass1, ev1, ec1, first1}, {3'b101, 4'd8, 3'd0}); end
  endtask
  task automatic test_settle3;
    start3 = 1'b1;
    cyc();
    start3 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      checks++; if ({busy3, done3, in3} !== {2'b10, 3'(i / 3)}) begin errors++; $display("FAIL settle3_cyc%0d got %h exp %h", i, {busy3, done3, in3}, {2'b10, 3'(i / 3)}); end
      cyc();
    end
    checks++; if ({busy3, done3, pass3, ec3} !== {3'b011, 4'd0}) begin errors++; $display("FAIL settle3_result got %b exp 0110000", {busy3, done3, pass3, ec3}); end
  endtask
  task automatic test_reset_mid;
    mode = 4;
    pulse1();
    cyc(3);
    checks++; if ({busy1, ev1} !== 2'b11) begin errors++; $display("FAIL mid_precond got %b exp 11", {busy1, ev1}); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if ({in1, busy1, done1, pass1, ec1, ev1, first1} !== 15'd0) begin errors++; $display("FAIL mid_reset got %h exp 0", {in1, busy1, done1, pass1, ec1, ev1, first1}); end
    cyc(3);
    checks++; if ({in1, busy1, done1} !== 5'd0) begin errors++; $display("FAIL mid_idle got %h exp 0", {in1, busy1, done1}); end
    mode = 0;
    pulse1();
    cyc(8);
    checks++; if ({done1, pass1, ec1} !== {2'b11, 4'd0}) begin errors++; $display("FAIL mid_resweep got %b exp 110000", {done1, pass1, ec1}); end
  endtask
  task automatic test_back_to_back;
    mode = 0;
    pulse1();
    cyc(2);
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    checks++; if ({busy1, in1} !== {1'b1, 3'd3}) begin errors++; $display("FAIL busy_start got %h exp b", {busy1, in1}); end
    cyc(4);
    checks++; if ({busy1, done1, in1} !== {2'b10, 3'd7}) begin errors++; $display("FAIL pre_done got %h exp 17", {busy1, done1, in1}); end
    cyc();
    checks++; if ({busy1, done1} !== 2'b01) begin errors++; $display("FAIL done_at_8 got %b exp 01", {busy1, done1}); end
    start1 = 1'b1;
    cyc();
    checks++; if ({busy1, done1, in1} !== {2'b10, 3'd0}) begin errors++; $display("FAIL restart1 got %h exp 10", {busy1, done1, in1}); end
    cyc(8);
    checks++; if ({busy1, done1, pass1} !== 3'b011) begin errors++; $display("FAIL b2b_done got %b exp 011", {busy1, done1, pass1}); end
    cyc();
    checks++; if ({busy1, done1, in1} !== {2'b10, 3'd0}) begin errors++; $display("FAIL restart2 got %h exp 10", {busy1, done1, in1}); end
    start1 = 1'b0;
    cyc(8);
    checks++; if ({busy1, done1, pass1} !== 3'b011) begin errors++; $display("FAIL b2b_end got %b exp 011", {busy1, done1, pass1}); end
  endtask
  initial begin
    test_reset();
    test_majority();
    test_mismatch();
    test_constants();
    test_settle3();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
